// File: rtl/vga_px_reader.sv
// rtl/vga_px_reader.sv - VGA timing generator and 4x-scaled frame-buffer pixel reader
module vga_px_reader #(
    parameter int H_VIS = 640,
    parameter int H_FP  = 16,
    parameter int H_SYN = 96,
    parameter int H_BP  = 48,
    parameter int V_VIS = 480,
    parameter int V_FP  = 10,
    parameter int V_SYN = 2,
    parameter int V_BP  = 33,
    parameter int FB_W  = 160,
    parameter int FB_H  = 120,
    parameter int AW    = 15,
    parameter int DW    = 3
) (
    input  logic          clk,
    input  logic          rst,
    output logic [AW-1:0] mem_px_addr,
    input  logic [DW-1:0] mem_px_data,
    output logic          vga_r,
    output logic          vga_g,
    output logic          vga_b,
    output logic          vga_hs,
    output logic          vga_vs,
    output logic          vblank,
    output logic          frame_start
);

    localparam int H_TOT = H_VIS + H_FP + H_SYN + H_BP;
    localparam int V_TOT = V_VIS + V_FP + V_SYN + V_BP;
    localparam int HW    = $clog2(H_TOT);
    localparam int VW    = $clog2(V_TOT);

    logic [HW-1:0] h_cnt_q, h_cnt_d;
    logic [VW-1:0] v_cnt_q, v_cnt_d;
    logic          visible, hs_raw, vs_raw;
    logic [AW-1:0] px_x, px_y, row_base, addr_d;

    // Stage 1 registers: address plus the timing flags that travel with it
    logic          vis1_q, hs1_q, vs1_q;
    // Stage 2 registers: flags delayed to line up with the RAM read data
    logic          vis2_q, hs2_q, vs2_q;
    // Stage 3 registers: outputs
    logic [2:0]    rgb_q;
    logic          hs_q, vs_q;
    logic          vblank_q, frame_start_q;

    // Counter next-state: h wraps every line, v advances only on the h wrap
    always_comb begin
        h_cnt_d = h_cnt_q + 1'b1;
        v_cnt_d = v_cnt_q;
        if (h_cnt_q == HW'(H_TOT - 1)) begin
            h_cnt_d = '0;
            if (v_cnt_q == VW'(V_TOT - 1)) begin
                v_cnt_d = '0;
            end else begin
                v_cnt_d = v_cnt_q + 1'b1;
            end
        end
    end

    // Decode visibility, raw syncs and the scaled frame-buffer address from the counters
    always_comb begin
        visible = (h_cnt_q < HW'(H_VIS)) && (v_cnt_q < VW'(V_VIS));
        hs_raw  = !((h_cnt_q >= HW'(H_VIS + H_FP)) && (h_cnt_q < HW'(H_VIS + H_FP + H_SYN)));
        vs_raw  = !((v_cnt_q >= VW'(V_VIS + V_FP)) && (v_cnt_q < VW'(V_VIS + V_FP + V_SYN)));
        px_x    = AW'(h_cnt_q >> 2);
        px_y    = AW'(v_cnt_q >> 2);
        // 160 = 128 + 32, so the row base is two shifts and an add
        if (FB_W == 160) begin
            row_base = (px_y << 7) + (px_y << 5);
        end else begin
            row_base = px_y * AW'(FB_W);
        end
        addr_d = visible ? (row_base + px_x) : '0;
    end

    // Free-running raster counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    // Three-stage pixel pipeline: address issue, RAM latency, colour/sync output
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_px_addr <= '0;
            vis1_q      <= 1'b0;
            hs1_q       <= 1'b1;
            vs1_q       <= 1'b1;
            vis2_q      <= 1'b0;
            hs2_q       <= 1'b1;
            vs2_q       <= 1'b1;
            rgb_q       <= '0;
            hs_q        <= 1'b1;
            vs_q        <= 1'b1;
        end else begin
            mem_px_addr <= addr_d;
            vis1_q      <= visible;
            hs1_q       <= hs_raw;
            vs1_q       <= vs_raw;
            vis2_q      <= vis1_q;
            hs2_q       <= hs1_q;
            vs2_q       <= vs1_q;
            rgb_q       <= vis2_q ? mem_px_data[2:0] : 3'b000;
            hs_q        <= hs2_q;
            vs_q        <= vs2_q;
        end
    end

    // Frame status flags, one clock behind the counters (not pipeline-aligned)
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vblank_q      <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            vblank_q      <= (v_cnt_q >= VW'(V_VIS));
            frame_start_q <= (h_cnt_q == '0) && (v_cnt_q == '0);
        end
    end

    assign vga_r       = rgb_q[2];
    assign vga_g       = rgb_q[1];
    assign vga_b       = rgb_q[0];
    assign vga_hs      = hs_q;
    assign vga_vs      = vs_q;
    assign vblank      = vblank_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_px_reader.sv
// tb/tb_vga_px_reader.sv - directed and scoreboard checks for vga_px_reader
module tb_vga_px_reader;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // Full-size instance (default VGA timing)
    logic [14:0] addr_b;
    logic [2:0]  data_b;
    logic        r_b, g_b, b_b, hs_b, vs_b, vbl_b, fs_b;

    // Reduced-size instance: 24 x 13 raster, 4 x 2 frame buffer, frame = 312 clk
    logic [2:0]  addr_s;
    logic [2:0]  data_s;
    logic        r_s, g_s, b_s, hs_s, vs_s, vbl_s, fs_s;
    logic [2:0]  ram_s [8];

    int checks = 0;
    int failures = 0;
    int n = 0;

    vga_px_reader u_big (
        .clk(clk), .rst(rst),
        .mem_px_addr(addr_b), .mem_px_data(data_b),
        .vga_r(r_b), .vga_g(g_b), .vga_b(b_b),
        .vga_hs(hs_b), .vga_vs(vs_b),
        .vblank(vbl_b), .frame_start(fs_b)
    );

    vga_px_reader #(
        .H_VIS(16), .H_FP(2), .H_SYN(3), .H_BP(3),
        .V_VIS(8), .V_FP(1), .V_SYN(2), .V_BP(2),
        .FB_W(4), .FB_H(2), .AW(3), .DW(3)
    ) u_small (
        .clk(clk), .rst(rst),
        .mem_px_addr(addr_s), .mem_px_data(data_s),
        .vga_r(r_s), .vga_g(g_s), .vga_b(b_s),
        .vga_hs(hs_s), .vga_vs(vs_s),
        .vblank(vbl_s), .frame_start(fs_s)
    );

    // Synchronous RAM models, one clock of read latency
    always @(posedge clk) begin
        data_s <= ram_s[addr_s];
        data_b <= (addr_b == 15'd0) ? 3'b101 : 3'b010;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s n=%0d observed=%0h expected=%0h", tag, n, obs, exp);
        end
    endtask

    task automatic check_reset();
        chk("rst_addr_b", 32'(addr_b), 0);
        chk("rst_rgb_b",  32'({r_b, g_b, b_b}), 0);
        chk("rst_hs_b",   32'(hs_b), 1);
        chk("rst_vs_b",   32'(vs_b), 1);
        chk("rst_vbl_b",  32'(vbl_b), 0);
        chk("rst_fs_b",   32'(fs_b), 0);
        chk("rst_addr_s", 32'(addr_s), 0);
        chk("rst_rgb_s",  32'({r_s, g_s, b_s}), 0);
        chk("rst_hs_s",   32'(hs_s), 1);
        chk("rst_vs_s",   32'(vs_s), 1);
        chk("rst_vbl_s",  32'(vbl_s), 0);
        chk("rst_fs_s",   32'(fs_s), 0);
    endtask

    // n = number of rising edges since reset release; counter state k was present k edges after release
    task automatic check_cycle();
        int k, h, v, vis, exp_rgb, exp_hs, exp_vs, exp_addr;
        // small instance: outputs reflect the counter state 3 edges back
        if (n < 3) begin
            exp_rgb = 0; exp_hs = 1; exp_vs = 1;
        end else begin
            k = n - 3;
            h = k % 24;
            v = (k / 24) % 13;
            vis = (h < 16) && (v < 8);
            exp_rgb = vis ? int'(ram_s[(v / 4) * 4 + (h / 4)]) : 0;
            exp_hs = (h >= 18 && h <= 20) ? 0 : 1;
            exp_vs = (v >= 9 && v <= 10) ? 0 : 1;
        end
        chk("s_rgb", 32'({r_s, g_s, b_s}), exp_rgb);
        chk("s_hs",  32'(hs_s), exp_hs);
        chk("s_vs",  32'(vs_s), exp_vs);
        // address, vblank and frame_start reflect the state 1 edge back
        k = n - 1;
        h = k % 24;
        v = (k / 24) % 13;
        vis = (h < 16) && (v < 8);
        exp_addr = vis ? (v / 4) * 4 + (h / 4) : 0;
        chk("s_addr", 32'(addr_s), exp_addr);
        chk("s_vblank", 32'(vbl_s), (v >= 8) ? 1 : 0);
        chk("s_frame_start", 32'(fs_s), (k % 312 == 0) ? 1 : 0);

        // full-size instance: directed points
        chk("b_vs_high", 32'(vs_b), 1);
        chk("b_vblank_low", 32'(vbl_b), 0);
        case (n)
            1:    begin chk("b_addr_first", 32'(addr_b), 0); chk("b_fs_first", 32'(fs_b), 1); end
            2:    chk("b_fs_width", 32'(fs_b), 0);
            3:    chk("b_rgb_first", 32'({r_b, g_b, b_b}), 3'b101);
            658:  chk("b_hs_before_fall", 32'(hs_b), 1);
            659:  chk("b_hs_fall", 32'(hs_b), 0);
            754:  chk("b_hs_before_rise", 32'(hs_b), 0);
            755:  chk("b_hs_rise", 32'(hs_b), 1);
            1459: chk("b_hs_period", 32'(hs_b), 0);
            3205: chk("b_addr_h4v4", 32'(addr_b), 161);
            3840: chk("b_addr_h639v4", 32'(addr_b), 319);
            3841: chk("b_addr_h640", 32'(addr_b), 0);
            3843: chk("b_rgb_h640", 32'({r_b, g_b, b_b}), 0);
            default: ;
        endcase
        if (n < 659) chk("b_hs_idle", 32'(hs_b), 1);
    endtask

    task automatic run(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            n = n + 1;
            @(negedge clk);
            check_cycle();
        end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) ram_s[i] = 3'($urandom_range(0, 7));
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_reset();

        // release, run 13+ small frames and past line 4 of the full-size raster
        rst = 1'b1;
        n = 0;
        run(4301);

        // asynchronous reset mid-frame, away from a clock edge
        #2;
        rst = 1'b0;
        #1;
        check_reset();
        repeat (5) @(posedge clk);
        @(negedge clk);
        check_reset();
        for (int i = 0; i < 8; i++) ram_s[i] = 3'b111;
        rst = 1'b1;
        n = 0;
        run(1000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
